// File: rtl/mssd_frame_sched.sv
// mssd_frame_sched: round-robin frame scheduler serialising START/DEST/LEN/DATA/STOP frames with gap and retry.
module mssd_frame_sched #(
  parameter int GAP = 2,
  parameter int MAX_RETRY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [11:0] len,
  input  logic [31:0] data,
  input  logic        err_in,
  output logic        serOut,
  output logic [3:0]  gnt,
  output logic        busy,
  output logic        done,
  output logic        drop
);
  typedef enum logic [2:0] {IDLE, START, DEST, LEN, DATA, STOP, GAPW} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d, gnt_d;
  logic [1:0] dest_q, dest_d, ptr_q, ptr_d, retry_q, retry_d, k;
  logic [2:0] l_q, l_d;
  logic [7:0] dat_q, dat_d;
  logic err_q, err_d, ser_d, done_d, drop_d, hit;
  always_comb begin
    k = ptr_q;
    hit = 1'b0;
    for (int i = 3; i >= 0; i--)
      if (req[ptr_q + 2'(i)]) begin
        k = ptr_q + 2'(i);
        hit = 1'b1;
      end
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + 4'd1;
    dest_d = dest_q;
    ptr_d = ptr_q;
    retry_d = retry_q;
    l_d = l_q;
    dat_d = dat_q;
    gnt_d = 4'b0;
    done_d = 1'b0;
    drop_d = 1'b0;
    err_d = err_q | ((state_q == STOP || state_q == GAPW) & err_in);
    case (state_q)
      IDLE: begin
        cnt_d = 4'd0;
        if (hit) begin
          state_d = START;
          dest_d = k;
          l_d = 3'(len >> (4'd3 * 4'(k)));
          dat_d = 8'(data >> {k, 3'b000});
          ptr_d = k + 2'd1;
          gnt_d = 4'b0001 << k;
          err_d = 1'b0;
        end
      end
      START: {state_d, cnt_d} = {DEST, 4'd0};
      DEST: if (cnt_q == 4'd1) {state_d, cnt_d} = {LEN, 4'd0};
      LEN: if (cnt_q == 4'd2) {state_d, cnt_d} = {DATA, 4'd0};
      DATA: if (cnt_q == {1'b0, l_q}) {state_d, cnt_d} = {STOP, 4'd0};
      STOP: {state_d, cnt_d} = {GAPW, 4'd0};
      GAPW: if (cnt_q == 4'(GAP - 1)) begin
        cnt_d = 4'd0;
        if (err_d && retry_q != 2'(MAX_RETRY)) begin
          state_d = START;
          retry_d = retry_q + 2'd1;
        end else begin
          state_d = IDLE;
          retry_d = 2'd0;
          done_d = ~err_d;
          drop_d = err_d;
        end
        err_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    ser_d = state_d == START ? 1'b0 :
            state_d == DEST  ? dest_d[~cnt_d[0]] :
            state_d == LEN   ? l_d[2'd2 - cnt_d[1:0]] :
            state_d == DATA  ? dat_d[l_d - cnt_d[2:0]] : 1'b1;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q <= 4'd0;
      dest_q <= 2'd0;
      ptr_q <= 2'd0;
      retry_q <= 2'd0;
      l_q <= 3'd0;
      dat_q <= 8'd0;
      err_q <= 1'b0;
      serOut <= 1'b1;
      gnt <= 4'b0;
      busy <= 1'b0;
      done <= 1'b0;
      drop <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      dest_q <= dest_d;
      ptr_q <= ptr_d;
      retry_q <= retry_d;
      l_q <= l_d;
      dat_q <= dat_d;
      err_q <= err_d;
      serOut <= ser_d;
      gnt <= gnt_d;
      busy <= state_d != IDLE;
      done <= done_d;
      drop <= drop_d;
    end
  end
endmodule

// File: tb/tb_mssd_frame_sched.sv
// tb_mssd_frame_sched: directed and randomized frames checked against a transaction-level model.
module tb_mssd_frame_sched;
  localparam int GAP = 2;
  localparam int MAX_RETRY = 1;
  logic clk = 1'b0, rst, err_in, serOut, busy, done, drop;
  logic [3:0] req, gnt;
  logic [11:0] len;
  logic [31:0] data;
  int checks = 0, passed = 0, ptr_m = 0;
  bit exp_q[$];
  mssd_frame_sched #(.GAP(GAP), .MAX_RETRY(MAX_RETRY)) dut (
    .clk(clk), .rst(rst), .req(req), .len(len), .data(data), .err_in(err_in),
    .serOut(serOut), .gnt(gnt), .busy(busy), .done(done), .drop(drop)
  );
  always #5 clk = ~clk;
  task automatic chk(input logic [3:0] o, input logic [3:0] e, input string t);
    checks++;
    assert (o === e) passed++;
    else $error("FAIL %s: got %0h want %0h", t, o, e);
  endtask
  task automatic step(input logic es, input logic [3:0] eg, input logic eb, input logic ed,
                      input logic edr, input string t);
    @(posedge clk);
    #1;
    chk({3'b0, serOut}, {3'b0, es}, {t, ".ser"});
    chk(gnt, eg, {t, ".gnt"});
    chk({3'b0, busy}, {3'b0, eb}, {t, ".busy"});
    chk({3'b0, done}, {3'b0, ed}, {t, ".done"});
    chk({3'b0, drop}, {3'b0, edr}, {t, ".drop"});
  endtask
  function automatic int pick(input logic [3:0] r, input int p);
    for (int i = 0; i < 4; i++) if (r[(p + i) % 4]) return (p + i) % 4;
    return 0;
  endfunction
  task automatic build(input logic [1:0] d, input logic [2:0] l, input logic [7:0] x);
    exp_q = {};
    exp_q.push_back(1'b0);
    exp_q.push_back(d[1]);
    exp_q.push_back(d[0]);
    for (int i = 2; i >= 0; i--) exp_q.push_back(l[i]);
    for (int i = int'(l); i >= 0; i--) exp_q.push_back(x[i]);
    for (int i = 0; i <= GAP; i++) exp_q.push_back(1'b1);
  endtask
  task automatic noise();
    req = 4'($urandom);
    len = 12'($urandom);
    data = $urandom;
  endtask
  task automatic do_frame(input logic [3:0] r, input logic [11:0] lv, input logic [31:0] dv,
                          input int pct, input string t);
    int k, att, n;
    logic e;
    req = r;
    len = lv;
    data = dv;
    err_in = 1'($urandom);
    k = pick(r, ptr_m);
    build(2'(k), lv[3*k +: 3], dv[8*k +: 8]);
    ptr_m = (k + 1) % 4;
    n = exp_q.size();
    att = 0;
    do begin
      e = 1'b0;
      for (int c = 0; c < n; c++) begin
        step(exp_q[c], (att == 0 && c == 0) ? 4'b0001 << k : 4'b0, 1'b1, 1'b0, 1'b0, t);
        noise();
        if (c >= n - GAP - 1) begin
          err_in = ($urandom_range(0, 99) < pct);
          e |= err_in;
        end else err_in = 1'($urandom);
      end
      att++;
    end while (e && att <= MAX_RETRY);
    step(1'b1, 4'b0, 1'b0, ~e, e, {t, ".end"});
  endtask
  task automatic reset_mid();
    int k;
    req = 4'($urandom_range(1, 15));
    len = 12'($urandom);
    data = $urandom;
    k = pick(req, ptr_m);
    build(2'(k), len[3*k +: 3], data[8*k +: 8]);
    for (int c = 0; c < 7; c++) begin
      step(exp_q[c], c == 0 ? 4'b0001 << k : 4'b0, 1'b1, 1'b0, 1'b0, "rmid");
      noise();
      err_in = 1'($urandom);
    end
    rst = 1'b0;
    step(1'b1, 4'b0, 1'b0, 1'b0, 1'b0, "rmid.rst");
    rst = 1'b1;
    ptr_m = 0;
  endtask
  initial begin
    rst = 1'b0;
    req = 4'hF;
    len = 12'h0;
    data = 32'h0;
    err_in = 1'b1;
    step(1'b1, 4'b0, 1'b0, 1'b0, 1'b0, "rst0");
    step(1'b1, 4'b0, 1'b0, 1'b0, 1'b0, "rst1");
    rst = 1'b1;
    req = 4'b0;
    step(1'b1, 4'b0, 1'b0, 1'b0, 1'b0, "idle");
    do_frame(4'hF, 12'h0, $urandom, 0, "first");
    do_frame(4'b0100, 12'h080, 32'h00A50000, 0, "single");
    for (int i = 0; i < 5; i++) do_frame(4'hF, 12'h0, $urandom, 0, "rr");
    do_frame(4'hF, 12'($urandom), $urandom, 100, "exhaust");
    do_frame(4'hF, 12'hFFF, 32'h81818181, 0, "maxlen");
    reset_mid();
    do_frame(4'hF, 12'($urandom), $urandom, 0, "postrst");
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0)
        for (int j = 0; j < int'($urandom_range(1, 3)); j++) begin
          req = 4'b0;
          err_in = 1'($urandom);
          step(1'b1, 4'b0, 1'b0, 1'b0, 1'b0, "gap");
        end
      do_frame(4'($urandom_range(1, 15)), 12'($urandom), $urandom, 15, "rnd");
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
